// File: rtl/feature_split_pkg.sv
// feature_split_pkg: shared state encoding, default profile and helpers for feature_split_sched
package feature_split_pkg;
  typedef enum logic [1:0] {IDLE, EMIT, WAIT_RND} state_t;
  localparam int TOTAL_F_MAX_DEF = 4095;
  localparam int NUM_CORE_DEF = 64;
  localparam int F_PER_CORE_DEF = 32;
  localparam int EW_DEF = 16;
  localparam int CITESEER_F = 3703;
  function automatic int unsigned ceil_shift(input int unsigned v, input int sh);
    return (v + (32'd1 << sh) - 32'd1) >> sh;
  endfunction
endpackage

// File: rtl/feature_split_sched_calc.sv
// split_chunk_calc: sizes the next chunk of an edge against the cores still free in the round
module split_chunk_calc #(
  parameter int FW = 12,
  parameter int CW = 6,
  parameter int PW = 5
) (
  input  logic [FW-1:0] tot_f,
  input  logic [FW-1:0] cur_f,
  input  logic [CW:0]   cores_left,
  output logic [CW:0]   cnt,
  output logic [FW-1:0] f_hi,
  output logic          last
);
  logic [FW:0] rem, need;
  assign rem  = {1'b0, tot_f} - {1'b0, cur_f};
  assign need = (rem + (FW+1)'((1 << PW) - 1)) >> PW;
  assign last = need <= (FW+1)'(cores_left);
  assign cnt  = last ? need[CW:0] : cores_left;
  assign f_hi = last ? tot_f : cur_f + (FW'(cores_left) << PW);
endmodule

// File: rtl/feature_split_sched.sv
// feature_split_sched: splits each edge's feature range into per-round core assignment chunks
module feature_split_sched
  import feature_split_pkg::*;
#(
  parameter int TOTAL_F_MAX = TOTAL_F_MAX_DEF,
  parameter int NUM_CORE    = NUM_CORE_DEF,
  parameter int F_PER_CORE  = F_PER_CORE_DEF,
  parameter int EW          = EW_DEF,
  parameter int FW          = $clog2(TOTAL_F_MAX + 1),
  parameter int CW          = $clog2(NUM_CORE),
  parameter int PW          = $clog2(F_PER_CORE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [FW-1:0] cfg_total_f,
  input  logic          e_valid,
  output logic          e_ready,
  input  logic [EW-1:0] e_id,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [EW-1:0] a_edge,
  output logic [FW-1:0] a_f_lo,
  output logic [FW-1:0] a_f_hi,
  output logic [CW-1:0] a_core_base,
  output logic [CW:0]   a_core_cnt,
  output logic          a_last,
  output logic          need_multi,
  input  logic          flush,
  output logic          rnd_full,
  input  logic          rnd_go
);
  localparam logic [CW:0] NC = (CW+1)'(NUM_CORE);
  state_t        state_q, state_d;
  logic [FW-1:0] cur_f_q, cur_f_d, tot_f_q, tot_f_d;
  logic [CW:0]   cores_left_q, cores_left_d;
  logic          edge_pend_q, edge_pend_d, need_multi_q, need_multi_d;
  logic [EW-1:0] id_q, id_d, a_edge_q, a_edge_d;
  logic [FW-1:0] a_f_lo_q, a_f_lo_d, a_f_hi_q, a_f_hi_d;
  logic [CW-1:0] a_core_base_q, a_core_base_d;
  logic [CW:0]   a_core_cnt_q, a_core_cnt_d, calc_cnt, base_w;
  logic          a_last_q, a_last_d, calc_last, flush_go, load;
  logic [FW-1:0] calc_f_hi;
  // a flush only closes a round that already has cores handed out
  assign flush_go    = state_q == IDLE && flush && cores_left_q != NC;
  assign e_ready     = state_q == IDLE && !flush_go;
  assign a_valid     = state_q == EMIT;
  assign rnd_full    = state_q == WAIT_RND;
  assign a_edge      = a_edge_q;
  assign a_f_lo      = a_f_lo_q;
  assign a_f_hi      = a_f_hi_q;
  assign a_core_base = a_core_base_q;
  assign a_core_cnt  = a_core_cnt_q;
  assign a_last      = a_last_q;
  assign need_multi  = need_multi_q;
  always_comb begin
    state_d      = state_q;
    cur_f_d      = cur_f_q;
    tot_f_d      = tot_f_q;
    cores_left_d = cores_left_q;
    edge_pend_d  = edge_pend_q;
    need_multi_d = need_multi_q;
    id_d         = id_q;
    case (state_q)
      IDLE:
        if (flush_go) state_d = WAIT_RND;
        else if (e_valid) begin
          id_d         = e_id;
          tot_f_d      = cfg_total_f;
          cur_f_d      = '0;
          edge_pend_d  = 1'b1;
          need_multi_d = ceil_shift(32'(cfg_total_f), PW) > 32'(NUM_CORE);
          state_d      = EMIT;
        end
      EMIT:
        if (a_ready) begin
          cores_left_d = cores_left_q - a_core_cnt_q;
          cur_f_d      = a_f_hi_q;
          edge_pend_d  = !a_last_q;
          state_d      = (!a_last_q || cores_left_q == a_core_cnt_q) ? WAIT_RND : IDLE;
        end
      WAIT_RND:
        if (rnd_go) begin
          cores_left_d = NC;
          state_d      = edge_pend_q ? EMIT : IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  // the chunk is sized from next-state values so it is ready the cycle EMIT begins
  split_chunk_calc #(.FW(FW), .CW(CW), .PW(PW)) u_calc (
    .tot_f     (tot_f_d),
    .cur_f     (cur_f_d),
    .cores_left(cores_left_d),
    .cnt       (calc_cnt),
    .f_hi      (calc_f_hi),
    .last      (calc_last)
  );
  assign load   = state_d == EMIT && state_q != EMIT;
  assign base_w = NC - cores_left_d;
  always_comb begin
    a_edge_d      = load ? id_d : a_edge_q;
    a_f_lo_d      = load ? cur_f_d : a_f_lo_q;
    a_f_hi_d      = load ? calc_f_hi : a_f_hi_q;
    a_core_base_d = load ? base_w[CW-1:0] : a_core_base_q;
    a_core_cnt_d  = load ? calc_cnt : a_core_cnt_q;
    a_last_d      = load ? calc_last : a_last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_f_q       <= '0;
      tot_f_q       <= '0;
      cores_left_q  <= NC;
      edge_pend_q   <= 1'b0;
      need_multi_q  <= 1'b0;
      id_q          <= '0;
      a_edge_q      <= '0;
      a_f_lo_q      <= '0;
      a_f_hi_q      <= '0;
      a_core_base_q <= '0;
      a_core_cnt_q  <= '0;
      a_last_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_f_q       <= cur_f_d;
      tot_f_q       <= tot_f_d;
      cores_left_q  <= cores_left_d;
      edge_pend_q   <= edge_pend_d;
      need_multi_q  <= need_multi_d;
      id_q          <= id_d;
      a_edge_q      <= a_edge_d;
      a_f_lo_q      <= a_f_lo_d;
      a_f_hi_q      <= a_f_hi_d;
      a_core_base_q <= a_core_base_d;
      a_core_cnt_q  <= a_core_cnt_d;
      a_last_q      <= a_last_d;
    end
  end
endmodule
